// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
//   mem_state_t : access sequencer state (IDLE / BUSY)
//   exmem_t     : EX/MEM pipeline register payload
//   memwb_t     : MEM/WB pipeline register payload
package mem_stage_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned REG_W       = 5;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MEM_LAT_MAX = 15;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic              memwrite;
        logic [DATA_W-1:0] aluout;
        logic [DATA_W-1:0] writedata;
        logic [REG_W-1:0]  writereg;
    } exmem_t;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic [DATA_W-1:0] readdata;
        logic [DATA_W-1:0] aluout;
        logic [REG_W-1:0]  writereg;
    } memwb_t;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: combinational read, write on the rising edge.
// Contents are never reset.
//   clk     : rising-edge clock
//   we      : write enable
//   addr    : word index
//   wdata   : write data
//   rdata_c : combinational read data at addr
module data_mem
    import mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage array write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata_c = mem_q[addr];

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM register, multi-cycle data
// memory access sequencer, and MEM/WB register feeding writeback.
//   clk, clr                          : clock, synchronous active-high reset
//   regwriteE..writeregE              : instruction arriving from execute
//   regwriteM, writeregM, aluoutM     : EX/MEM view for forwarding/hazards
//   stallM                            : hold upstream stages and PC
//   misalignM                         : MEM instruction is a misaligned load/store
//   regwriteW..writeregW              : registered results to writeback
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              memwriteE,
    input  logic [DATA_W-1:0] aluoutE,
    input  logic [DATA_W-1:0] writedataE,
    input  logic [REG_W-1:0]  writeregE,
    output logic              regwriteM,
    output logic [REG_W-1:0]  writeregM,
    output logic [DATA_W-1:0] aluoutM,
    output logic              stallM,
    output logic              misalignM,
    output logic              regwriteW,
    output logic              memtoregW,
    output logic [DATA_W-1:0] readdataW,
    output logic [DATA_W-1:0] aluoutW,
    output logic [REG_W-1:0]  writeregW
);

    localparam int unsigned AW = $clog2(DEPTH);
    // First BUSY count; only meaningful when MEM_LAT > 1.
    localparam logic [CNT_W-1:0] CNT_INIT = (MEM_LAT > 1) ? CNT_W'(MEM_LAT - 2) : '0;

    // Elaboration-time parameter checks
    if ((MEM_LAT < 1) || (MEM_LAT > MEM_LAT_MAX)) begin : g_bad_mem_lat
        $error("memory_stage: MEM_LAT=%0d outside 1..%0d", MEM_LAT, MEM_LAT_MAX);
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("memory_stage: DEPTH=%0d is not a power of 2", DEPTH);
    end

    exmem_t            exmem_q, exmem_d;
    memwb_t            memwb_q, memwb_d;
    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              mem_op;
    logic              misalign;
    logic              access;
    logic              complete;
    logic              stall;
    logic              mem_we;
    logic [AW-1:0]     word_idx;
    logic [DATA_W-1:0] rdata;

    // Access sequencer: classifies the MEM instruction and counts out latency
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;

        mem_op   = exmem_q.memtoreg | exmem_q.memwrite;
        misalign = mem_op & (exmem_q.aluout[1:0] != 2'b00);
        access   = mem_op & ~misalign;
        word_idx = exmem_q.aluout[AW+1:2];

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (MEM_LAT == 1) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // clr drops a store that would otherwise complete on this edge
        mem_we = complete & exmem_q.memwrite & ~clr;
    end

    // EX/MEM next value: load from execute unless stalled
    always_comb begin
        exmem_d = exmem_q;
        if (!stall) begin
            exmem_d.regwrite  = regwriteE;
            exmem_d.memtoreg  = memtoregE;
            exmem_d.memwrite  = memwriteE;
            exmem_d.aluout    = aluoutE;
            exmem_d.writedata = writedataE;
            exmem_d.writereg  = writeregE;
        end
    end

    // MEM/WB next value: bubble while stalled so writeback sees each op once
    always_comb begin
        memwb_d = '0;
        if (!stall) begin
            memwb_d.regwrite = exmem_q.regwrite & ~misalign;
            memwb_d.memtoreg = exmem_q.memtoreg;
            memwb_d.readdata = (access & exmem_q.memtoreg) ? rdata : '0;
            memwb_d.aluout   = exmem_q.aluout;
            memwb_d.writereg = exmem_q.writereg;
        end
    end

    // Pipeline and sequencer registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    data_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_mem (
        .clk     (clk),
        .we      (mem_we),
        .addr    (word_idx),
        .wdata   (exmem_q.writedata),
        .rdata_c (rdata)
    );

    assign regwriteM = exmem_q.regwrite;
    assign writeregM = exmem_q.writereg;
    assign aluoutM   = exmem_q.aluout;
    assign stallM    = stall;
    assign misalignM = misalign;

    assign regwriteW = memwb_q.regwrite;
    assign memtoregW = memwb_q.memtoreg;
    assign readdataW = memwb_q.readdata;
    assign aluoutW   = memwb_q.aluout;
    assign writeregW = memwb_q.writereg;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: four instances with MEM_LAT 1..4,
// directed scenarios plus random op streams checked against a
// transaction-level model (per-op MEM occupancy, W trace, word memory).
module tb_memory_stage;

    localparam int NI    = 4;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr         [NI];
    logic        regwrite_e  [NI];
    logic        memtoreg_e  [NI];
    logic        memwrite_e  [NI];
    logic [31:0] aluout_e    [NI];
    logic [31:0] writedata_e [NI];
    logic [4:0]  writereg_e  [NI];
    logic        regwrite_m  [NI];
    logic [4:0]  writereg_m  [NI];
    logic [31:0] aluout_m    [NI];
    logic        stall_m     [NI];
    logic        misalign_m  [NI];
    logic        regwrite_w  [NI];
    logic        memtoreg_w  [NI];
    logic [31:0] readdata_w  [NI];
    logic [31:0] aluout_w    [NI];
    logic [4:0]  writereg_w  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        memory_stage #(
            .DEPTH   (DEPTH),
            .MEM_LAT (g + 1)
        ) u_dut (
            .clk        (clk),
            .clr        (clr[g]),
            .regwriteE  (regwrite_e[g]),
            .memtoregE  (memtoreg_e[g]),
            .memwriteE  (memwrite_e[g]),
            .aluoutE    (aluout_e[g]),
            .writedataE (writedata_e[g]),
            .writeregE  (writereg_e[g]),
            .regwriteM  (regwrite_m[g]),
            .writeregM  (writereg_m[g]),
            .aluoutM    (aluout_m[g]),
            .stallM     (stall_m[g]),
            .misalignM  (misalign_m[g]),
            .regwriteW  (regwrite_w[g]),
            .memtoregW  (memtoreg_w[g]),
            .readdataW  (readdata_w[g]),
            .aluoutW    (aluout_w[g]),
            .writeregW  (writereg_w[g])
        );
    end

    typedef struct {
        logic        rw;
        logic        mtr;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wr;
    } op_t;

    op_t         ops_q [$];
    logic [31:0] model_mem [NI][DEPTH];
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input int inst,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s inst%0d: observed 0x%08h expected 0x%08h", tag, inst, obs, exp);
        end
    endtask

    function automatic op_t mk(input logic rw, input logic mtr, input logic mw,
                               input logic [31:0] alu, input logic [31:0] wd,
                               input logic [4:0] wr);
        op_t o;
        o.rw = rw; o.mtr = mtr; o.mw = mw; o.alu = alu; o.wd = wd; o.wr = wr;
        return o;
    endfunction

    function automatic op_t nop_op();
        return mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endfunction

    function automatic op_t st_op(input logic [31:0] addr, input logic [31:0] data);
        return mk(1'b0, 1'b0, 1'b1, addr, data, 5'd0);
    endfunction

    function automatic op_t ld_op(input logic [31:0] addr, input logic [4:0] wr);
        return mk(1'b1, 1'b1, 1'b0, addr, 32'h0, wr);
    endfunction

    function automatic op_t alu_op(input logic [31:0] val, input logic [4:0] wr);
        return mk(1'b1, 1'b0, 1'b0, val, 32'h0, wr);
    endfunction

    function automatic op_t rand_op();
        logic [31:0] a;
        int          kind;
        a    = $urandom;
        kind = $urandom_range(0, 3);
        if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
        else                           a[1:0] = 2'b00;
        case (kind)
            0:       return alu_op(a, 5'($urandom_range(0, 31)));
            1:       return st_op(a, $urandom);
            default: return ld_op(a, 5'($urandom_range(0, 31)));
        endcase
    endfunction

    task automatic drive(input int inst, input op_t o);
        regwrite_e[inst]  = o.rw;
        memtoreg_e[inst]  = o.mtr;
        memwrite_e[inst]  = o.mw;
        aluout_e[inst]    = o.alu;
        writedata_e[inst] = o.wd;
        writereg_e[inst]  = o.wr;
    endtask

    task automatic check_zero(input int inst, input string tag);
        check({tag, ".regwriteM"}, inst, 32'(regwrite_m[inst]), 32'h0);
        check({tag, ".writeregM"}, inst, 32'(writereg_m[inst]), 32'h0);
        check({tag, ".aluoutM"},   inst, aluout_m[inst],        32'h0);
        check({tag, ".stallM"},    inst, 32'(stall_m[inst]),    32'h0);
        check({tag, ".misalignM"}, inst, 32'(misalign_m[inst]), 32'h0);
        check({tag, ".regwriteW"}, inst, 32'(regwrite_w[inst]), 32'h0);
        check({tag, ".memtoregW"}, inst, 32'(memtoreg_w[inst]), 32'h0);
        check({tag, ".readdataW"}, inst, readdata_w[inst],      32'h0);
        check({tag, ".aluoutW"},   inst, aluout_w[inst],        32'h0);
        check({tag, ".writeregW"}, inst, 32'(writereg_w[inst]), 32'h0);
    endtask

    // Issue ops_q back to back into one instance. Each op occupies MEM for
    // MEM_LAT cycles if it is an aligned load/store, else one cycle; every
    // MEM cycle except the last is a stall and sends a bubble to W.
    // clr_at >= 0 pulses clr during that MEM cycle and abandons the stream.
    task automatic run_stream(input int inst, input int clr_at);
        int          lat;
        int          k;
        logic        erw, emtr;
        logic [31:0] ealu, erd;
        logic [4:0]  ewr;
        lat = inst + 1;
        k   = 0;
        erw = 1'b0; emtr = 1'b0; ealu = 32'h0; erd = 32'h0; ewr = 5'd0;
        ops_q.push_back(nop_op());
        @(negedge clk);
        drive(inst, ops_q[0]);
        @(posedge clk);
        for (int i = 0; i < ops_q.size(); i++) begin
            op_t o;
            logic memop, mis;
            int   cost, idx;
            o     = ops_q[i];
            memop = o.mtr | o.mw;
            mis   = memop && (o.alu[1:0] != 2'b00);
            cost  = (memop && !mis) ? lat : 1;
            idx   = int'((o.alu / 32'd4) % DEPTH);
            for (int s = 0; s < cost; s++) begin
                @(negedge clk);
                check("regwriteM", inst, 32'(regwrite_m[inst]), 32'(o.rw));
                check("writeregM", inst, 32'(writereg_m[inst]), 32'(o.wr));
                check("aluoutM",   inst, aluout_m[inst],        o.alu);
                check("stallM",    inst, 32'(stall_m[inst]),    32'(s != cost - 1));
                check("misalignM", inst, 32'(misalign_m[inst]), 32'(mis));
                check("regwriteW", inst, 32'(regwrite_w[inst]), 32'(erw));
                check("memtoregW", inst, 32'(memtoreg_w[inst]), 32'(emtr));
                check("aluoutW",   inst, aluout_w[inst],        ealu);
                check("writeregW", inst, 32'(writereg_w[inst]), 32'(ewr));
                if (emtr) check("readdataW", inst, readdata_w[inst], erd);
                if (k == clr_at) begin
                    clr[inst] = 1'b1;
                    drive(inst, nop_op());
                    @(posedge clk);
                    @(negedge clk);
                    check_zero(inst, "clr_mid");
                    clr[inst] = 1'b0;
                    ops_q.delete();
                    return;
                end
                if (s == cost - 1) begin
                    erw  = o.rw && !mis;
                    emtr = o.mtr;
                    ealu = o.alu;
                    ewr  = o.wr;
                    erd  = (o.mtr && !mis) ? model_mem[inst][idx] : 32'h0;
                    if (o.mw && !mis) model_mem[inst][idx] = o.wd;
                    drive(inst, (i + 1 < ops_q.size()) ? ops_q[i + 1] : nop_op());
                end else begin
                    erw = 1'b0; emtr = 1'b0; ealu = 32'h0; erd = 32'h0; ewr = 5'd0;
                end
                @(posedge clk);
                k++;
            end
        end
        ops_q.delete();
    endtask

    initial begin
        for (int n = 0; n < NI; n++) begin
            clr[n] = 1'b1;
            drive(n, nop_op());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int n = 0; n < NI; n++) check_zero(n, "reset");
        for (int n = 0; n < NI; n++) clr[n] = 1'b0;

        // Give every word a known value
        for (int n = 0; n < NI; n++) begin
            for (int w = 0; w < DEPTH; w++) ops_q.push_back(st_op(32'(w * 4), $urandom));
            run_stream(n, -1);
        end

        // MEM_LAT=1: store then load, no stalls
        ops_q.push_back(st_op(32'h10, 32'hDEADBEEF));
        ops_q.push_back(ld_op(32'h10, 5'd7));
        run_stream(0, -1);

        // MEM_LAT=3: single load
        ops_q.push_back(ld_op(32'h20, 5'd9));
        run_stream(2, -1);

        // Misaligned store leaves word 0x10 alone
        ops_q.push_back(st_op(32'h13, 32'hCAFEF00D));
        ops_q.push_back(ld_op(32'h10, 5'd4));
        run_stream(1, -1);

        // MEM_LAT=4: clr on the second stall cycle of a store, then reload
        ops_q.push_back(st_op(32'h40, 32'h12345678));
        run_stream(3, 1);
        ops_q.push_back(ld_op(32'h40, 5'd5));
        run_stream(3, -1);

        // Address wrap: 0x100 aliases word 0
        ops_q.push_back(st_op(32'h100, 32'h5));
        ops_q.push_back(ld_op(32'h000, 5'd6));
        run_stream(1, -1);

        // Back-to-back ALU / store / load / ALU to one word
        ops_q.push_back(alu_op(32'h24, 5'd3));
        ops_q.push_back(st_op(32'h24, 32'hA5A5_0F0F));
        ops_q.push_back(ld_op(32'h24, 5'd8));
        ops_q.push_back(alu_op(32'h0000_1234, 5'd10));
        run_stream(1, -1);

        // Random streams on every latency
        for (int n = 0; n < NI; n++) begin
            for (int j = 0; j < 40; j++) ops_q.push_back(rand_op());
            run_stream(n, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

MEM stage of the 5-stage MIPS pipeline, directly upstream of the writeback stage. It holds the EX/MEM pipeline register, a word-addressed data memory with configurable multi-cycle access latency, and the MEM/WB pipeline register. It drives `memtoregW`, `readdataW` and `aluoutW` straight into the writeback result mux. It stalls the front of the pipeline while a slow access is in flight.

## Interface
- `DEPTH`, 64: data memory size in 32-bit words; power of 2.
- `MEM_LAT`, 2: cycles a load/store occupies MEM; legal range 1..15.

- `clk`  in  1  rising-edge clock.
- `clr`  in  1  synchronous, active-high reset.
- `regwriteE`, `memtoregE`, `memwriteE`  in  1 each  control from execute.
- `aluoutE`  in  32  ALU result / byte address.
- `writedataE`  in  32  store data.
- `writeregE`  in  5  destination register.
- `regwriteM`  out  1  forwarding/hazard view of the EX/MEM register.
- `writeregM`  out  5  forwarding/hazard view of the EX/MEM register.
- `aluoutM`  out  32  forwarding/hazard view of the EX/MEM register.
- `stallM`  out  1  upstream stages and PC must hold while high.
- `misalignM`  out  1  high while the MEM instruction is a misaligned load/store.
- `regwriteW`, `memtoregW`  out  1 each  registered control to writeback.
- `readdataW`, `aluoutW`  out  32 each  registered data to writeback.
- `writeregW`  out  5  registered destination register to writeback.

## Operation
- **EX/MEM register**
  - Loads all E inputs at the clock edge when `stallM`=0.
  - Holds its contents when `stallM`=1.
- **Memory operation and addressing**
  - An instruction is a memory op when `memtoregM | memwriteM`.
  - Word index = `aluoutM[log2(DEPTH)+1:2]`; upper address bits are ignored, so the index wraps modulo DEPTH.
- **Misaligned access** (`aluoutM[1:0]`≠0 on a memory op)
  - `misalignM`=1; no stall; no memory write.
  - MEM/WB receives `readdataW`=0 and `regwriteW`=0.
- **FSM states**: IDLE and BUSY, with a 4-bit counter `cnt`.
- **IDLE**
  - Aligned memory op with `MEM_LAT`=1: completes this cycle; `stallM`=0.
  - Aligned memory op with `MEM_LAT`>1: `stallM`=1; next state BUSY with `cnt`←`MEM_LAT`-2.
  - Non-memory op: `stallM`=0.
- **BUSY**
  - `stallM` = (`cnt`≠0).
  - `cnt`≠0: decrement `cnt`.
  - `cnt`=0: the access completes; next state IDLE.
- **Completion cycle**
  - Store: memory word written at this edge, exactly once per store.
  - Load: array read combinationally and captured into `readdataW`.
- **MEM/WB register**
  - `stallM`=0: captures the `regwriteM`/`memtoregM`/`aluoutM`/`writeregM`/read-data path.
  - `stallM`=1: loads a bubble (all fields 0), so writeback never repeats an instruction.
- **Memory contents**
  - Not reset; `clr` leaves them unchanged.
  - A load after a store to the same word returns the stored data.
- **`clr`**
  - FSM returns to IDLE and `cnt`=0.
  - EX/MEM and MEM/WB registers are zeroed.
  - A store in progress is dropped (no write).
  - `clr` takes priority over everything.

## Timing
- **Reset values** (cycle after `clr`): all W outputs = 0; `regwriteM`, `writeregM`, `aluoutM` = 0; `stallM`=0; `misalignM`=0.
- **Latency**
  - E inputs are visible on M outputs 1 cycle later.
  - A non-memory op reaches W outputs 2 cycles after E.
  - A memory op reaches W outputs `MEM_LAT`+1 cycles after E.
- **Stall**
  - `stallM` is combinational from state, `cnt` and the EX/MEM contents.
  - A load/store raises it for exactly `MEM_LAT`-1 consecutive cycles.
- **`misalignM`**: combinational; asserted for the single cycle the instruction sits in MEM.
- **Back-to-back memory ops**: the second op enters MEM on the completion edge of the first and starts its own access in the next cycle (IDLE).

## Structure
- **Package `mem_stage_pkg`**
  - `typedef enum logic {IDLE, BUSY} mem_state_t`.
  - `localparam MEM_LAT_MAX = 15`.
  - Packed struct `exmem_t`: regwrite, memtoreg, memwrite, aluout, writedata, writereg.
  - Packed struct `memwb_t`: regwrite, memtoreg, readdata, aluout, writereg.
- **Sub-module `data_mem`**: DEPTH×32 array, combinational read, write on the clock edge with write-enable; no reset.
- **Parameter check**: elaboration-time assertion on `MEM_LAT` range and on DEPTH being a power of 2.

## Test plan
- **Latency 1 store/load**: `MEM_LAT`=1; store 0xDEADBEEF to address 0x10, then load 0x10 → `stallM` never asserts; `readdataW`=0xDEADBEEF and `memtoregW`=1 two cycles after the load's E cycle.
- **Latency 3 load**: `MEM_LAT`=3; load from 0x20 → `stallM` high exactly 2 cycles; W shows 2 bubble cycles (`regwriteW`=0), then the load with correct data.
- **Misaligned store**: store to 0x13 → `misalignM`=1 for 1 cycle, no stall, memory word 0x10 unchanged, `regwriteW`=0.
- **Reset mid-access**: `MEM_LAT`=4; assert `clr` on the 2nd stall cycle of a store to 0x40 → next cycle all outputs 0 and state IDLE; a subsequent load of 0x40 returns its old value.
- **Address wrap**: `DEPTH`=64; store 0x5 to address 0x100, then load 0x000 → `readdataW`=0x5.
- **Back-to-back**: `MEM_LAT`=2; an ALU op, a store, a load and an ALU op to the same word issued consecutively → the store and load each stall 1 cycle, the load returns the stored value, and the ALU op reaches W with `regwriteW`=1, `memtoregW`=0.
